alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//   Parametrised, handshaked successor to the datapath ALU. Accepts one op per cycle
//   via valid/ready, registers result plus zero/carry/negative flags, and provides an
//   iterative multi-cycle shifter (1 bit/cycle). Sits between decode and register
//   writeback; the output stage holds under downstream backpressure.
// PARAMETERS
//   WIDTH    10                  result / in2 / work-register width
//   IN1_W    8                   in1 width; zero-extended to WIDTH before use (IN1_W <= WIDTH)
//   SHAMT_W  $clog2(WIDTH)       shift-amount bits, taken from in1[SHAMT_W-1:0]
// PORTS
//   clk        in   1        clock; all state updates on posedge
//   rst        in   1        synchronous reset, active-high
//   in_valid   in   1        op/operands valid
//   in_ready   out  1        block can accept this cycle
//   opcode     in   3        000 PASS,001 ADD,010 SUB,011 INC,100 SHR,101 SHL,110 AND,111 XOR
//   in1        in   IN1_W    operand A / shift amount
//   in2        in   WIDTH    operand B / shift source
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer takes result
//   out1       out  WIDTH    result
//   flag_z     out  1        out1 == 0
//   flag_c     out  1        carry/borrow/shifted-out bit
//   flag_n     out  1        out1[WIDTH-1]
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state IDLE, out_valid=0, out1=0, flags=0, shift count=0.
//     in_ready=0 while rst high. Reset mid-shift aborts the op; no result emitted.
//   - FSM: IDLE, SHIFT. in_ready = (state==IDLE) && !rst && (!out_valid || out_ready).
//   - Accept on in_valid && in_ready at edge T.
//   - Non-shift ops: out1/flags/out_valid written at edge T (latency 1); back-to-back
//     accepts give 1 result/cycle.
//   - SHR/SHL, n=in1[SHAMT_W-1:0]: n=0 behaves as latency 1, out1=in2, c=0. n>=1: load
//     work=in2, cnt=n, go SHIFT; each edge shift 1 bit (zero fill), cnt--; on the edge
//     where cnt==1 write result, out_valid=1, return IDLE -> out_valid after edge T+n.
//     in_ready=0 throughout SHIFT. n>=WIDTH yields 0 after n cycles.
//   - Output slot is always free when SHIFT completes (accept requires slot freeing).
//   - out_valid && !out_ready: out1/flags held stable, in_ready=0.
//   - out_valid falls on out_ready edge unless a new result is written the same edge.
//   - Arithmetic on WIDTH+1 bits: ADD c=carry-out; SUB c=borrow (in2 < zext(in1));
//     INC c=carry-out of in2+1; shifts c=last bit shifted out; PASS/AND/XOR c=0.
//   - flag_z/flag_n computed from the result being written, never the previous out1.
//   - opcode/in1/in2 are don't-care when not accepted.
// CONFIGURATION
//   ALU_SAT_EN defined: ADD/INC overflow clamps out1 to all-ones; SUB underflow clamps
//     to 0; flag_c still reports the overflow/borrow event; z/n from clamped value.
//   ALU_SAT_EN undefined: ADD/INC/SUB wrap modulo 2^WIDTH.
// TESTING
//   1 ADD in1=8'h05 in2=10'h3FE, out_ready=1 -> next cycle out1=10'h003 c=1 z=0 n=0
//     (ALU_SAT_EN: out1=10'h3FF c=1 n=1).
//   2 SUB in1=8'h05 in2=10'h005 -> out1=0 z=1 c=0; SUB in1=8'h06 in2=10'h005 ->
//     out1=10'h3FF c=1 n=1 (ALU_SAT_EN: out1=0 z=1 c=1).
//   3 SHR in1=8'h03 in2=10'h201 at edge T -> in_ready=0 for 3 cycles, out_valid after
//     edge T+3, out1=10'h040 c=0; SHL in1=8'h01 in2=10'h200 -> out1=0 z=1 c=1.
//   4 Stream 4 ADDs (in2=1..4, in1=1) on consecutive cycles, out_ready=1 -> out1=2,3,4,5
//     on 4 consecutive cycles, in_ready stays 1.
//   5 out_ready=0 after first ADD result -> in_ready=0, out1/flags stable 5 cycles;
//     raise out_ready -> pending op accepted same edge, its result next cycle.
//   6 rst=1 two cycles into SHR n=8 -> out_valid=0, out1=0, flags=0, IDLE; first
//     post-reset op completes normally.

Source files
------------

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags and an iterative 1-bit-per-cycle shifter.
// Optional ALU_SAT_EN: ADD/INC clamp to all-ones on overflow, SUB clamps to zero on borrow.
module alu_pipe #(
  parameter int WIDTH   = 10,
  parameter int IN1_W   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [IN1_W-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

`ifdef ALU_SAT_EN
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH:0] raw, input logic is_sub);
    if (raw[WIDTH]) return is_sub ? '0 : '1;
    return raw[WIDTH-1:0];
  endfunction
`endif

  logic [0:0]         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic               dir_shl_q, dir_shl_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out1_q, out1_d;
  logic               flag_z_q, flag_z_d;
  logic               flag_c_q, flag_c_d;
  logic               flag_n_q, flag_n_d;

  logic               accept;
  logic               wr;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     b_ext;
  logic [WIDTH:0]     raw;
  logic [WIDTH-1:0]   sh_nxt;
  logic               sh_bit;
  logic [SHAMT_W-1:0] sh_n;

  assign in_ready = (state_q == ST_IDLE) && !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign a_ext    = (WIDTH+1)'(in1);
  assign b_ext    = {1'b0, in2};
  assign sh_n     = in1[SHAMT_W-1:0];

  // Zero-fill single-bit step; sh_bit is the bit leaving the register this cycle.
  assign sh_nxt = dir_shl_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
  assign sh_bit = dir_shl_q ? work_q[WIDTH-1] : work_q[0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    dir_shl_d   = dir_shl_q;
    out_valid_d = out_valid_q && !out_ready;
    out1_d      = out1_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    flag_n_d    = flag_n_q;
    wr          = 1'b0;
    res         = '0;
    res_c       = 1'b0;
    raw         = '0;

    if (state_q == ST_SHIFT) begin
      work_d = sh_nxt;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == SHAMT_W'(1)) begin
        wr      = 1'b1;
        res     = sh_nxt;
        res_c   = sh_bit;
        state_d = ST_IDLE;
      end
    end else if (accept) begin
      case (opcode)
        OP_PASS: begin wr = 1'b1; res = in2; end
        OP_ADD, OP_SUB, OP_INC: begin
          case (opcode)
            OP_ADD:  raw = b_ext + a_ext;
            OP_SUB:  raw = b_ext - a_ext;
            default: raw = b_ext + 1'b1;
          endcase
          wr    = 1'b1;
          res_c = raw[WIDTH];
`ifdef ALU_SAT_EN
          res   = clamp(raw, opcode == OP_SUB);
`else
          res   = raw[WIDTH-1:0];
`endif
        end
        OP_SHR, OP_SHL: begin
          if (sh_n == '0) begin
            wr  = 1'b1;
            res = in2;
          end else begin
            work_d    = in2;
            cnt_d     = sh_n;
            dir_shl_d = (opcode == OP_SHL);
            state_d   = ST_SHIFT;
          end
        end
        OP_AND:  begin wr = 1'b1; res = in2 & a_ext[WIDTH-1:0]; end
        OP_XOR:  begin wr = 1'b1; res = in2 ^ a_ext[WIDTH-1:0]; end
        default: begin wr = 1'b0; end
      endcase
    end

    if (wr) begin
      out_valid_d = 1'b1;
      out1_d      = res;
      flag_z_d    = (res == '0);
      flag_c_d    = res_c;
      flag_n_d    = res[WIDTH-1];
    end
  end

  // Control and output stage; reset aborts any shift in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out1_q      <= '0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_n_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out1_q      <= out1_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      flag_n_q    <= flag_n_d;
    end
  end

  // Shifter work register is pure data and only meaningful while in SHIFT.
  always_ff @(posedge clk) begin
    work_q    <= work_d;
    dir_shl_q <= dir_shl_d;
  end

  assign out_valid = out_valid_q;
  assign out1      = out1_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign flag_n    = flag_n_q;

endmodule
